// File: rtl/gpio_int_ctrl_pkg.sv
// ============================================================================
// gpio_int_pkg : shared types and register-map constants for gpio_int_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

package gpio_int_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } gpio_int_state_e;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    localparam logic [2:0] ADDR_PEND = 3'd0;
    localparam logic [2:0] ADDR_MASK = 3'd1;
    localparam logic [2:0] ADDR_ACK  = 3'd2;
    localparam logic [2:0] ADDR_PRIO = 3'd3;
    localparam logic [2:0] ADDR_GEN  = 3'd4;
    localparam logic [2:0] ADDR_DBG  = 3'd5;

    localparam int GEN_BIT = 0;

endpackage

`default_nettype wire

// File: rtl/gpio_int_ctrl_if.sv
// ============================================================================
// gpio_int_ctrl_if : GPIO-style register bus (Addr/DataRd/DataWr/En/Rd/Wr)
// Revision: 1.0
// ============================================================================
`default_nettype none

interface gpio_int_ctrl_if #(
    parameter int WIDTH = 16
);
    logic [2:0]       Addr;
    logic [WIDTH-1:0] DataRd;
    logic [WIDTH-1:0] DataWr;
    logic             En;
    logic             Rd;
    logic             Wr;

    modport master (
        output Addr, DataWr, En, Rd, Wr,
        input  DataRd
    );

    modport slave (
        input  Addr, DataWr, En, Rd, Wr,
        output DataRd
    );
endinterface

`default_nettype wire

// File: rtl/gpio_int_ctrl_prio_enc.sv
// ============================================================================
// gpio_int_prio_enc : combinational lowest-set-bit encoder with valid flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module gpio_int_prio_enc #(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  wire logic [WIDTH-1:0] Pending_i,
    output logic      [IDX_W-1:0] Index_o,
    output logic                  Valid_o
);

    // Scan downwards so the lowest set bit is the last one to win.
    always_comb begin
        Index_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (Pending_i[i]) begin
                Index_o = IDX_W'(i);
            end
        end
    end

    assign Valid_o = |Pending_i;

endmodule

`default_nettype wire

// File: rtl/gpio_int_ctrl.sv
// ============================================================================
// gpio_int_ctrl : masked/gated interrupt stage with Irq holdoff FSM and
//                 write-1-to-clear IntReset pulses. Optional macro:
//                 GPIO_INT_CTRL_PRIO_EN (priority index readout at addr 3).
// Revision: 1.0
// ============================================================================
`default_nettype none

module gpio_int_ctrl
    import gpio_int_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int HOLDOFF = 4,
    parameter int HCNT_W  = 8
) (
    input  wire logic             Clk,
    input  wire logic             Reset,
    gpio_int_ctrl_if.slave        bus,
    input  wire logic [WIDTH-1:0] IntStatus,
    output logic      [WIDTH-1:0] IntReset,
    output logic                  Irq
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int DBG_W = HCNT_W + 2;

    logic [WIDTH-1:0]  mask_q, mask_d;
    logic              gen_q, gen_d;
    logic [WIDTH-1:0]  intreset_q, intreset_d;
    logic              irq_q, irq_d;
    logic [1:0]        state_q, state_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;

    logic              w_wr;
    logic              w_wr_ack;
    logic              w_ack_hit;
    logic [WIDTH-1:0]  w_pending;
    logic [WIDTH-1:0]  w_ack_data;
    logic [WIDTH-1:0]  w_prio;
    logic [WIDTH-1:0]  w_rd;
    logic [DBG_W-1:0]  w_dbg;
    logic              w_unused_rd;

    assign w_wr       = bus.En & bus.Wr;
    assign w_wr_ack   = w_wr && (bus.Addr == ADDR_ACK);
    assign w_pending  = IntStatus & mask_q;
    assign w_ack_data = bus.DataWr & mask_q;
    assign w_ack_hit  = w_wr_ack && (|w_ack_data);
    assign w_dbg      = {state_q, hcnt_q};
    // Reads carry no side effects, so the read strobe is not decoded.
    assign w_unused_rd = bus.Rd;

    always_comb begin
        mask_d     = mask_q;
        gen_d      = gen_q;
        intreset_d = '0;
        if (w_wr && (bus.Addr == ADDR_MASK)) begin
            mask_d = bus.DataWr;
        end
        if (w_wr && (bus.Addr == ADDR_GEN)) begin
            gen_d = bus.DataWr[GEN_BIT];
        end
        if (w_wr_ack) begin
            intreset_d = w_ack_data;
        end
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (gen_q && (|w_pending)) begin
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (w_ack_hit) begin
                    if (HOLDOFF == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLDOFF;
                        hcnt_d  = HCNT_W'(HOLDOFF);
                    end
                end else if (!(|w_pending) || !gen_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLDOFF: begin
                if (hcnt_q <= HCNT_W'(1)) begin
                    state_d = ST_IDLE;
                    hcnt_d  = '0;
                end else begin
                    hcnt_d = hcnt_q - HCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                hcnt_d  = '0;
            end
        endcase
    end

    assign irq_d = (state_d == ST_ASSERT);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mask_q     <= '0;
            gen_q      <= 1'b0;
            intreset_q <= '0;
            irq_q      <= 1'b0;
            state_q    <= ST_IDLE;
            hcnt_q     <= '0;
        end else begin
            mask_q     <= mask_d;
            gen_q      <= gen_d;
            intreset_q <= intreset_d;
            irq_q      <= irq_d;
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
        end
    end

`ifdef GPIO_INT_CTRL_PRIO_EN
    logic [IDX_W-1:0] w_idx;
    logic             w_valid;

    gpio_int_prio_enc #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .Pending_i (w_pending),
        .Index_o   (w_idx),
        .Valid_o   (w_valid)
    );

    always_comb begin
        w_prio              = '0;
        w_prio[IDX_W-1:0]   = w_idx;
        w_prio[WIDTH-1]     = w_valid;
    end
`else
    assign w_prio = '0;
`endif

    always_comb begin
        w_rd = '0;
        if (bus.En) begin
            case (bus.Addr)
                ADDR_PEND: w_rd = w_pending;
                ADDR_MASK: w_rd = mask_q;
                ADDR_ACK:  w_rd = IntStatus;
                ADDR_PRIO: w_rd = w_prio;
                ADDR_GEN:  w_rd = {{(WIDTH-1){1'b0}}, gen_q};
                ADDR_DBG:  w_rd = WIDTH'(w_dbg);
                default:   w_rd = '0;
            endcase
        end
    end

    assign bus.DataRd = w_rd;
    assign IntReset   = intreset_q;
    assign Irq        = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_int_ctrl.sv
// ============================================================================
// tb_gpio_int_ctrl : directed self-checking bench for gpio_int_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gpio_int_ctrl;

    logic        Clk;
    logic        Reset;
    logic [15:0] IntStatus;
    logic [15:0] IntReset;
    logic        Irq;

    int n_cmp;
    int n_bad;

    gpio_int_ctrl_if #(.WIDTH(16)) bus ();

    gpio_int_ctrl #(
        .WIDTH   (16),
        .HOLDOFF (4),
        .HCNT_W  (8)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .bus       (bus.slave),
        .IntStatus (IntStatus),
        .IntReset  (IntReset),
        .Irq       (Irq)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        bus.Addr   = a;
        bus.DataWr = d;
        bus.En     = 1'b1;
        bus.Wr     = 1'b1;
        tick();
        bus.En     = 1'b0;
        bus.Wr     = 1'b0;
        bus.DataWr = 16'h0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        bus.Addr = a;
        bus.En   = 1'b1;
        bus.Rd   = 1'b1;
        #1;
        d        = bus.DataRd;
        bus.En   = 1'b0;
        bus.Rd   = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        Reset     = 1'b1;
        IntStatus = 16'hFFFF;
        tick();
        tick();
        n_cmp++; if (Irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", Irq); end
        n_cmp++; if (IntReset !== 16'h0) begin n_bad++; $display("FAIL reset_intreset: got %h want 0000", IntReset); end
        bus_read(3'd1, d);
        n_cmp++; if (d !== 16'h0) begin n_bad++; $display("FAIL reset_mask: got %h want 0000", d); end
        bus_read(3'd5, d);
        n_cmp++; if (d !== 16'h0) begin n_bad++; $display("FAIL reset_dbg: got %h want 0000", d); end
        IntStatus = 16'h0;
        Reset     = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [15:0] d;
        do_reset();
        bus_write(3'd1, 16'h0010);
        bus_write(3'd4, 16'h0001);
        n_cmp++; if (Irq !== 1'b0) begin n_bad++; $display("FAIL basic_idle_irq: got %b want 0", Irq); end
        IntStatus = 16'h0010;
        tick();
        n_cmp++; if (Irq !== 1'b1) begin n_bad++; $display("FAIL basic_irq: got %b want 1", Irq); end
        bus_read(3'd0, d);
        n_cmp++; if (d !== 16'h0010) begin n_bad++; $display("FAIL basic_pending: got %h want 0010", d); end
        bus_read(3'd5, d);
        n_cmp++; if (d !== 16'h0100) begin n_bad++; $display("FAIL basic_dbg: got %h want 0100", d); end
        bus_read(3'd4, d);
        n_cmp++; if (d !== 16'h0001) begin n_bad++; $display("FAIL basic_gen_rd: got %h want 0001", d); end
    endtask

    // Continues from test_basic: ASSERT with IntStatus=0010 held.
    task automatic test_back_to_back();
        logic [15:0] d;
        bus_write(3'd2, 16'h0010);
        n_cmp++; if (IntReset !== 16'h0010) begin n_bad++; $display("FAIL ack_pulse: got %h want 0010", IntReset); end
        n_cmp++; if (Irq !== 1'b0) begin n_bad++; $display("FAIL ack_irq_low: got %b want 0", Irq); end
        bus_read(3'd5, d);
        n_cmp++; if (d !== 16'h0204) begin n_bad++; $display("FAIL ack_dbg4: got %h want 0204", d); end
        tick();
        n_cmp++; if (IntReset !== 16'h0) begin n_bad++; $display("FAIL ack_pulse_end: got %h want 0000", IntReset); end
        bus_read(3'd5, d);
        n_cmp++; if (d !== 16'h0203) begin n_bad++; $display("FAIL ack_dbg3: got %h want 0203", d); end
        bus_write(3'd2, 16'h0010);
        n_cmp++; if (IntReset !== 16'h0010) begin n_bad++; $display("FAIL holdoff_ack_pulse: got %h want 0010", IntReset); end
        bus_read(3'd5, d);
        n_cmp++; if (d !== 16'h0202) begin n_bad++; $display("FAIL holdoff_noreload: got %h want 0202", d); end
        tick();
        n_cmp++; if (Irq !== 1'b0) begin n_bad++; $display("FAIL holdoff_irq: got %b want 0", Irq); end
        n_cmp++; if (IntReset !== 16'h0) begin n_bad++; $display("FAIL holdoff_pulse_end: got %h want 0000", IntReset); end
        tick();
        bus_read(3'd5, d);
        n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL holdoff_exit: got %h want 0000", d); end
        n_cmp++; if (Irq !== 1'b0) begin n_bad++; $display("FAIL holdoff_exit_irq: got %b want 0", Irq); end
        tick();
        n_cmp++; if (Irq !== 1'b1) begin n_bad++; $display("FAIL reassert_irq: got %b want 1", Irq); end
    endtask

    task automatic test_masking();
        logic [15:0] d;
        do_reset();
        IntStatus = 16'h8001;
        bus_write(3'd1, 16'h0001);
        bus_read(3'd0, d);
        n_cmp++; if (d !== 16'h0001) begin n_bad++; $display("FAIL mask_pending: got %h want 0001", d); end
        bus_read(3'd2, d);
        n_cmp++; if (d !== 16'h8001) begin n_bad++; $display("FAIL mask_rawstatus: got %h want 8001", d); end
        bus_write(3'd2, 16'hFFFF);
        n_cmp++; if (IntReset !== 16'h0001) begin n_bad++; $display("FAIL mask_ack: got %h want 0001", IntReset); end
        bus_read(3'd5, d);
        n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL idle_ack_state: got %h want 0000", d); end
        bus_write(3'd2, 16'h8000);
        n_cmp++; if (IntReset !== 16'h0) begin n_bad++; $display("FAIL masked_ack_none: got %h want 0000", IntReset); end
    endtask

    // Continues from test_masking: Pending=0001, GlobalEn=0.
    task automatic test_global_enable();
        tick();
        n_cmp++; if (Irq !== 1'b0) begin n_bad++; $display("FAIL gen_off_irq: got %b want 0", Irq); end
        bus_write(3'd4, 16'h0001);
        tick();
        n_cmp++; if (Irq !== 1'b1) begin n_bad++; $display("FAIL gen_on_irq: got %b want 1", Irq); end
        bus_write(3'd4, 16'h0000);
        tick();
        n_cmp++; if (Irq !== 1'b0) begin n_bad++; $display("FAIL gen_drop_irq: got %b want 0", Irq); end
    endtask

    task automatic test_mask_zero();
        logic [15:0] d;
        do_reset();
        IntStatus = 16'h0004;
        bus_write(3'd1, 16'h0004);
        bus_write(3'd4, 16'h0001);
        tick();
        n_cmp++; if (Irq !== 1'b1) begin n_bad++; $display("FAIL mz_irq: got %b want 1", Irq); end
        bus_write(3'd1, 16'h0000);
        tick();
        n_cmp++; if (Irq !== 1'b0) begin n_bad++; $display("FAIL mz_irq_drop: got %b want 0", Irq); end
        bus_read(3'd5, d);
        n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL mz_state: got %h want 0000", d); end
    endtask

    task automatic test_prio_and_decode();
        logic [15:0] d;
        logic [15:0] exp_prio;
`ifdef GPIO_INT_CTRL_PRIO_EN
        exp_prio = 16'h8009;
`else
        exp_prio = 16'h0000;
`endif
        do_reset();
        IntStatus = 16'h0A00;
        bus_write(3'd1, 16'hFFFF);
        bus_read(3'd3, d);
        n_cmp++; if (d !== exp_prio) begin n_bad++; $display("FAIL prio: got %h want %h", d, exp_prio); end
        bus_write(3'd6, 16'hFFFF);
        bus_read(3'd6, d);
        n_cmp++; if (d !== 16'h0) begin n_bad++; $display("FAIL addr6: got %h want 0000", d); end
        bus_read(3'd7, d);
        n_cmp++; if (d !== 16'h0) begin n_bad++; $display("FAIL addr7: got %h want 0000", d); end
        bus.Addr = 3'd1;
        bus.En   = 1'b0;
        #1;
        n_cmp++; if (bus.DataRd !== 16'h0) begin n_bad++; $display("FAIL en_low_rd: got %h want 0000", bus.DataRd); end
    endtask

    task automatic test_holdoff_reset();
        logic [15:0] d;
        do_reset();
        IntStatus = 16'h0A00;
        bus_write(3'd1, 16'hFFFF);
        bus_write(3'd4, 16'h0001);
        tick();
        bus_write(3'd2, 16'h0200);
        bus_read(3'd5, d);
        n_cmp++; if (d !== 16'h0204) begin n_bad++; $display("FAIL hr_pre: got %h want 0204", d); end
        Reset = 1'b1;
        tick();
        bus_read(3'd5, d);
        n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL hr_state: got %h want 0000", d); end
        n_cmp++; if (IntReset !== 16'h0) begin n_bad++; $display("FAIL hr_intreset: got %h want 0000", IntReset); end
        bus_write(3'd2, 16'h0800);
        n_cmp++; if (IntReset !== 16'h0) begin n_bad++; $display("FAIL hr_drop_pulse: got %h want 0000", IntReset); end
        n_cmp++; if (Irq !== 1'b0) begin n_bad++; $display("FAIL hr_irq: got %b want 0", Irq); end
        Reset = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        Reset      = 1'b1;
        IntStatus  = 16'h0;
        bus.Addr   = 3'd0;
        bus.DataWr = 16'h0;
        bus.En     = 1'b0;
        bus.Rd     = 1'b0;
        bus.Wr     = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_masking();
        test_global_enable();
        test_mask_zero();
        test_prio_and_decode();
        test_holdoff_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
